// File: rtl/instr_fetcher.sv
// Single-outstanding instruction fetch stage between the wavefront PC and program memory.
// Optional macro INSTR_FETCH_REUSE_EN lets a repeated fetch of the last PC skip memory.
module instr_fetcher #(
    parameter int PROGRAM_MEM_ADDR_WIDTH = 32,
    parameter int INSTR_WIDTH            = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              enable,
    input  logic                              fetch_start,
    input  logic                              fetch_ack,
    input  logic                              flush,
    input  logic [PROGRAM_MEM_ADDR_WIDTH-1:0] pc_in,
    output logic                              mem_read_valid,
    output logic [PROGRAM_MEM_ADDR_WIDTH-1:0] mem_read_addr,
    input  logic                              mem_read_ready,
    input  logic [INSTR_WIDTH-1:0]            mem_read_data,
    output logic [INSTR_WIDTH-1:0]            instr_out,
    output logic                              fetch_done,
    output logic [1:0]                        fetch_state
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FETCHING = 2'd1,
        FETCHED  = 2'd2,
        ILLEGAL  = 2'd3
    } state_t;

    state_t                              state_r;
    state_t                              state_next_s;
    logic [PROGRAM_MEM_ADDR_WIDTH-1:0]   addr_r;
    logic [PROGRAM_MEM_ADDR_WIDTH-1:0]   addr_next_s;
    logic [INSTR_WIDTH-1:0]              instr_r;
    logic [INSTR_WIDTH-1:0]              instr_next_s;

`ifdef INSTR_FETCH_REUSE_EN
    logic [PROGRAM_MEM_ADDR_WIDTH-1:0]   last_pc_r;
    logic [PROGRAM_MEM_ADDR_WIDTH-1:0]   last_pc_next_s;
    logic                                last_valid_r;
    logic                                last_valid_next_s;
    logic                                reuse_hit_s;

    // A start on the most recently fetched PC can be satisfied from instr_out.
    always_comb begin
        reuse_hit_s = last_valid_r && (pc_in == last_pc_r);
    end
`endif

    // Next-state and datapath selection; flush overrides enable so a frozen stage can still be aborted.
    always_comb begin
        state_next_s = state_r;
        addr_next_s  = addr_r;
        instr_next_s = instr_r;
`ifdef INSTR_FETCH_REUSE_EN
        last_pc_next_s    = last_pc_r;
        last_valid_next_s = last_valid_r;
`endif
        if (flush) begin
            state_next_s = IDLE;
`ifdef INSTR_FETCH_REUSE_EN
            last_valid_next_s = 1'b0;
`endif
        end else if (!enable) begin
            state_next_s = state_r;
        end else begin
            case (state_r)
                IDLE: begin
                    if (fetch_start) begin
                        addr_next_s = pc_in;
`ifdef INSTR_FETCH_REUSE_EN
                        if (reuse_hit_s) begin
                            state_next_s = FETCHED;
                        end else begin
                            state_next_s = FETCHING;
                        end
`else
                        state_next_s = FETCHING;
`endif
                    end else begin
                        state_next_s = IDLE;
                    end
                end
                FETCHING: begin
                    if (mem_read_ready) begin
                        instr_next_s = mem_read_data;
                        state_next_s = FETCHED;
`ifdef INSTR_FETCH_REUSE_EN
                        last_pc_next_s    = addr_r;
                        last_valid_next_s = 1'b1;
`endif
                    end else begin
                        state_next_s = FETCHING;
                    end
                end
                FETCHED: begin
                    if (fetch_ack) begin
                        state_next_s = IDLE;
                    end else begin
                        state_next_s = FETCHED;
                    end
                end
                default: begin
                    state_next_s = IDLE;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            addr_r  <= '0;
            instr_r <= '0;
`ifdef INSTR_FETCH_REUSE_EN
            last_pc_r    <= '0;
            last_valid_r <= 1'b0;
`endif
        end else begin
            state_r <= state_next_s;
            addr_r  <= addr_next_s;
            instr_r <= instr_next_s;
`ifdef INSTR_FETCH_REUSE_EN
            last_pc_r    <= last_pc_next_s;
            last_valid_r <= last_valid_next_s;
`endif
        end
    end

    // Handshake and status outputs decode the state register only, never the inputs.
    always_comb begin
        mem_read_valid = (state_r == FETCHING);
        fetch_done     = (state_r == FETCHED);
        fetch_state    = state_r;
        mem_read_addr  = addr_r;
        instr_out      = instr_r;
    end

endmodule

// File: doc/instr_fetcher.md
# instr_fetcher

Per-SIMD instruction fetch stage, directly downstream of the wavefront PC register. It takes the current PC and issues a single-word read to program memory using a valid/ready handshake. It holds the returned instruction for the decoder and signals completion so the core scheduler can pulse `UPDATE_PC`. Only one outstanding request is allowed, and there is no branching.

## Interface
- `PROGRAM_MEM_ADDR_WIDTH`, 32: width of the PC and of the memory address.
- `INSTR_WIDTH`, 32: instruction word width.

- `clk` input 1: clock; all state updates on posedge.
- `rst` input 1: reset rst, synchronous, active-high.
- `enable` input 1: when low, all state and outputs hold, including mid-handshake.
- `fetch_start` input 1: scheduler request to fetch at `pc_in`; sampled only in IDLE.
- `fetch_ack` input 1: scheduler has consumed `instr_out`; sampled only in FETCHED.
- `flush` input 1: new wave dispatched (same cycle as `DISPATCH_NEW_WAVE`); aborts any fetch.
- `pc_in` input PROGRAM_MEM_ADDR_WIDTH: PC from the PC stage.
- `mem_read_valid` output 1: read request to program memory.
- `mem_read_addr` output PROGRAM_MEM_ADDR_WIDTH: request address, equal to the latched PC.
- `mem_read_ready` input 1: memory returns data this cycle; meaningful only while `mem_read_valid`=1.
- `mem_read_data` input INSTR_WIDTH: instruction word, valid when `mem_read_ready`=1.
- `instr_out` output INSTR_WIDTH: registered fetched instruction.
- `fetch_done` output 1: high in FETCHED.
- `fetch_state` output 2: encoded state (IDLE=0, FETCHING=1, FETCHED=2), for debug and scheduler.

## Operation
- **IDLE**: if `fetch_start` is high, latch `pc_in` into `addr_q` and go to FETCHING.
- **FETCHING**: `mem_read_valid`=1 and `mem_read_addr`=`addr_q`, held stable. On `mem_read_ready`=1:
  - `instr_out` <= `mem_read_data`
  - go to FETCHED
- **FETCHED**: `fetch_done`=1 and `instr_out` holds. On `fetch_ack` go to IDLE. A `fetch_start` arriving in FETCHED is ignored.
- `flush` has highest priority after `rst`. From any state it goes to IDLE and deasserts `mem_read_valid` the next cycle. A `mem_read_ready` in the same cycle is discarded and `instr_out` is not updated. `instr_out` retains its old value.
- `flush` together with `fetch_start` in IDLE: the flush wins and no request is issued.
- `enable`=0 freezes the FSM. `mem_read_valid` stays high if it was high, and `mem_read_ready` is ignored while disabled.
- State encoding 3 is unreachable; if it is ever entered, the next state is IDLE.
- `mem_read_valid` and `fetch_done` are driven combinationally from the state register only, never from inputs.

## Timing
- Reset values:
  - state IDLE
  - `mem_read_valid`=0
  - `mem_read_addr`=0
  - `instr_out`=0
  - `fetch_done`=0
  - `fetch_state`=0
- With `fetch_start` sampled at edge N, `mem_read_valid` is high after edge N.
- With `mem_read_ready` sampled at edge M, `instr_out` and `fetch_done` are valid after edge M and `mem_read_valid` is low after edge M.
- Minimum start-to-done latency is 2 edges (ready returned in the first FETCHING cycle).
- With `fetch_ack` sampled at edge K, the block is IDLE after K. A new `fetch_start` is accepted at K+1 at the earliest; there is no bypass.
- `rst` mid-handshake returns to IDLE immediately. Memory must tolerate a dropped request.

## Configuration
- Macro `INSTR_FETCH_REUSE_EN` enables last-instruction reuse.
- **Defined**: the block keeps `last_pc` and `last_valid`.
  - `last_valid` is set on every memory completion.
  - `last_valid` is cleared by `rst` and `flush`.
  - In IDLE, `fetch_start` with `last_valid`=1 and `pc_in`==`last_pc` goes directly to FETCHED with `instr_out` unchanged. `mem_read_valid` is never raised, and `fetch_done` is high after edge N.
- **Undefined**: every fetch goes to memory, and neither `last_pc` nor `last_valid` exists.

## Test plan
- **Reset**: assert `rst` 2 cycles with random inputs -> all outputs 0 and `fetch_state`=0.
- **Basic fetch**: `pc_in`=5, pulse `fetch_start`, memory returns ready after 3 cycles with data 0xDEADBEEF -> `mem_read_addr`=5 held for 3 cycles, `instr_out`=0xDEADBEEF, `fetch_done`=1 until `fetch_ack`, then IDLE.
- **Stall with enable**: drop `enable` for 4 cycles during FETCHING -> `mem_read_valid` stays 1, `mem_read_ready` is ignored, and the fetch completes only after `enable` returns.
- **Flush with ready**: assert `flush` in the same cycle as `mem_read_ready` with data 0x1234 -> IDLE next cycle, `instr_out` keeps its prior value, and `fetch_done` stays 0.
- **Back-to-back**: fetch PC 0 then PC 1 with `fetch_ack` then `fetch_start` on consecutive cycles -> two distinct requests, each with correct data, with one IDLE cycle between them.
- **Reuse** (`INSTR_FETCH_REUSE_EN` defined): fetch PC 7, ack, fetch PC 7 again -> second fetch has no `mem_read_valid` and `fetch_done` one edge after start. After `flush`, PC 7 goes to memory again.
